mem_stage_ctrl: RTL and testbench

//  Consumer side of the EX/MEM pipeline register: executes the MEM stage of the 5-stage MIPS pipe.

---
 rtl/mem_stage_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM stage of the 5-stage MIPS pipe.
//   Resolves branches, performs loads/stores over a variable-latency req/ack
//   data-memory handshake, stalls the upstream pipe while an access is
//   outstanding, and registers the MEM/WB outputs.
// Ports:
//   clk_i, rst_i                      clock (rising edge), async active-high reset
//   WB_*_i, M_*_i, Adder2_i, zero_i,
//   ALU_result_i, Write_data_i, MUX2_i  fields from the EX/MEM register
//   PCSrc_o, branch_target_o          branch resolution (combinational)
//   stall_o                           hold upstream pipe registers (combinational)
//   dmem_*                            data-memory request/ack interface
//   bus_err_o                         sticky misalign/timeout error
//   WB_RegWrite_o .. MUX2_o           MEM/WB register outputs
module mem_stage_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              WB_RegWrite_i,
  input  logic              WB_MemtoReg_i,
  input  logic              M_branch_i,
  input  logic              M_MemRead_i,
  input  logic              M_MemWrite_i,
  input  logic [DATA_W-1:0] Adder2_i,
  input  logic              zero_i,
  input  logic [DATA_W-1:0] ALU_result_i,
  input  logic [DATA_W-1:0] Write_data_i,
  input  logic [REG_W-1:0]  MUX2_i,
  output logic              PCSrc_o,
  output logic [DATA_W-1:0] branch_target_o,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  input  logic              dmem_ack_i,
  output logic              bus_err_o,
  output logic              WB_RegWrite_o,
  output logic              WB_MemtoReg_o,
  output logic [DATA_W-1:0] Read_data_o,
  output logic [DATA_W-1:0] ALU_result_o,
  output logic [REG_W-1:0]  MUX2_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               mem_op, misalign;
  logic               req, stall;
  logic               complete, bubble, load_ack, err_set;

  assign mem_op          = M_MemRead_i | M_MemWrite_i;
  assign misalign        = mem_op & (ALU_result_i[1:0] != 2'b00);
  assign PCSrc_o         = M_branch_i & zero_i;
  assign branch_target_o = Adder2_i;
  assign dmem_we_o       = M_MemWrite_i;
  assign dmem_addr_o     = ALU_result_i;
  assign dmem_wdata_o    = Write_data_i;

  // Gated by reset so an access in flight is withdrawn the moment reset hits.
  assign dmem_req_o = req & ~rst_i;
  assign stall_o    = stall & ~rst_i;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    req      = 1'b0;
    stall    = 1'b0;
    complete = 1'b0;
    bubble   = 1'b0;
    load_ack = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (!mem_op) begin
          complete = 1'b1;
        end else if (misalign) begin
          err_set = 1'b1;
          bubble  = 1'b1;
        end else begin
          req = 1'b1;
          if (dmem_ack_i) begin
            complete = 1'b1;
            load_ack = ~M_MemWrite_i;
          end else begin
            stall   = 1'b1;
            bubble  = 1'b1;
            state_n = WAIT;
            cnt_n   = CNT_W'(1);
          end
        end
      end
      WAIT: begin
        req = 1'b1;
        if (dmem_ack_i) begin
          complete = 1'b1;
          load_ack = ~M_MemWrite_i;
          state_n  = IDLE;
          cnt_n    = '0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          err_set = 1'b1;
          bubble  = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          stall  = 1'b1;
          bubble = 1'b1;
          cnt_n  = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      bus_err_o <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bus_err_o <= bus_err_o | err_set;
    end
  end

  // Bubbles clear only the control bits; data fields keep their last value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      WB_RegWrite_o <= 1'b0;
      WB_MemtoReg_o <= 1'b0;
      Read_data_o   <= '0;
      ALU_result_o  <= '0;
      MUX2_o        <= '0;
    end else if (complete) begin
      WB_RegWrite_o <= WB_RegWrite_i;
      WB_MemtoReg_o <= WB_MemtoReg_i;
      ALU_result_o  <= ALU_result_i;
      MUX2_o        <= MUX2_i;
      if (load_ack) begin
        Read_data_o <= dmem_rdata_i;
      end
    end else if (bubble) begin
      WB_RegWrite_o <= 1'b0;
      WB_MemtoReg_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          WB_RegWrite_i, WB_MemtoReg_i, M_branch_i, M_MemRead_i, M_MemWrite_i, zero_i;
  logic [DW-1:0] Adder2_i, ALU_result_i, Write_data_i, dmem_rdata_i;
  logic [RW-1:0] MUX2_i;
  logic          dmem_ack_i;
  logic          PCSrc_o, stall_o, dmem_req_o, dmem_we_o, bus_err_o;
  logic [DW-1:0] branch_target_o, dmem_addr_o, dmem_wdata_o;
  logic          WB_RegWrite_o, WB_MemtoReg_o;
  logic [DW-1:0] Read_data_o, ALU_result_o;
  logic [RW-1:0] MUX2_o;

  mem_stage_ctrl #(.DATA_W(DW), .REG_W(RW), .TIMEOUT(T)) dut (
    .clk_i(clk), .rst_i(rst),
    .WB_RegWrite_i(WB_RegWrite_i), .WB_MemtoReg_i(WB_MemtoReg_i),
    .M_branch_i(M_branch_i), .M_MemRead_i(M_MemRead_i), .M_MemWrite_i(M_MemWrite_i),
    .Adder2_i(Adder2_i), .zero_i(zero_i), .ALU_result_i(ALU_result_i),
    .Write_data_i(Write_data_i), .MUX2_i(MUX2_i),
    .PCSrc_o(PCSrc_o), .branch_target_o(branch_target_o), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
    .bus_err_o(bus_err_o), .WB_RegWrite_o(WB_RegWrite_o), .WB_MemtoReg_o(WB_MemtoReg_o),
    .Read_data_o(Read_data_o), .ALU_result_o(ALU_result_o), .MUX2_o(MUX2_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected MEM/WB contents, sticky error, and how many
  // cycles the current instruction has already spent in MEM.
  logic          m_rw, m_mtr, m_err, m_hold;
  logic [DW-1:0] m_rdata, m_alu;
  logic [RW-1:0] m_mux;
  int            age;
  bit            chk_en = 0;

  task automatic model_reset();
    m_rw = 0; m_mtr = 0; m_err = 0; m_hold = 0;
    m_rdata = '0; m_alu = '0; m_mux = '0; age = 0;
  endtask

  // Compare process: inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      automatic logic mem    = M_MemRead_i | M_MemWrite_i;
      automatic logic mis    = mem && (ALU_result_i[1:0] != 2'b00);
      automatic logic act    = mem && !mis;
      automatic logic e_stl  = act && !dmem_ack_i && (age < T - 1);
      automatic logic e_to   = act && !dmem_ack_i && (age == T - 1);
      automatic logic commit = !mem || (act && dmem_ack_i);
      chk("WB_RegWrite", WB_RegWrite_o, m_rw);
      chk("WB_MemtoReg", WB_MemtoReg_o, m_mtr);
      chk("Read_data", Read_data_o, m_rdata);
      chk("ALU_result", ALU_result_o, m_alu);
      chk("MUX2", MUX2_o, m_mux);
      chk("bus_err", bus_err_o, m_err);
      chk("PCSrc", PCSrc_o, M_branch_i & zero_i);
      chk("branch_target", branch_target_o, Adder2_i);
      chk("dmem_req", dmem_req_o, act);
      chk("stall", stall_o, e_stl);
      chk("dmem_we", dmem_we_o, M_MemWrite_i);
      chk("dmem_addr", dmem_addr_o, ALU_result_i);
      chk("dmem_wdata", dmem_wdata_o, Write_data_i);
      if (commit) begin
        m_rw  = WB_RegWrite_i;
        m_mtr = WB_MemtoReg_i;
        m_alu = ALU_result_i;
        m_mux = MUX2_i;
        if (act && !M_MemWrite_i) m_rdata = dmem_rdata_i;
      end else begin
        m_rw  = 0;
        m_mtr = 0;
      end
      if (mis || e_to) m_err = 1;
      m_hold = e_stl;
      age    = e_stl ? age + 1 : 0;
    end
  end

  // Presents one instruction (called just after a rising edge) and holds it
  // until the pipe would advance. lat = age at which ack is given (<0: none).
  task automatic issue(input logic rw, input logic mtr, input logic br, input logic z,
                       input logic rd, input logic wr, input logic [DW-1:0] adder,
                       input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                       input logic [DW-1:0] rdv, input logic [RW-1:0] mux, input int lat,
                       output int nstall, output int nreq);
    automatic int  n = 0;
    automatic logic act = (rd | wr) && (alu[1:0] == 2'b00);
    WB_RegWrite_i = rw; WB_MemtoReg_i = mtr; M_branch_i = br; zero_i = z;
    M_MemRead_i = rd; M_MemWrite_i = wr; Adder2_i = adder; ALU_result_i = alu;
    Write_data_i = wd; MUX2_i = mux;
    nstall = 0; nreq = 0;
    do begin
      dmem_ack_i   = act ? (age == lat) : 1'($urandom_range(0, 1));
      dmem_rdata_i = dmem_ack_i ? rdv : $urandom;
      #1;
      if (stall_o) nstall++;
      if (dmem_req_o) nreq++;
      @(posedge clk); #1;
      n++;
    end while (m_hold && n < 3 * T);
    if (m_hold) begin
      errors++;
      $display("FAIL issue_bound: instruction still held after %0d cycles", n);
    end
  endtask

  task automatic nop();
    int s, r;
    issue(0, 0, 0, 0, 0, 0, '0, '0, '0, '0, '0, -1, s, r);
  endtask

  initial begin
    int s, r;
    rst = 1;
    {WB_RegWrite_i, WB_MemtoReg_i, M_branch_i, M_MemRead_i, M_MemWrite_i, zero_i, dmem_ack_i} = '0;
    {Adder2_i, ALU_result_i, Write_data_i, dmem_rdata_i} = '0;
    MUX2_i = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req", dmem_req_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_bus_err", bus_err_o, 0);
    chk("rst_RegWrite", WB_RegWrite_o, 0);
    chk("rst_Read_data", Read_data_o, 0);
    rst = 0;
    chk_en = 1;

    // Zero-wait load
    issue(1, 1, 0, 0, 1, 0, '0, 32'h40, '0, 32'hDEADBEEF, 5'd3, 0, s, r);
    chk("load0_stalls", s, 0);
    chk("load0_rdata", Read_data_o, 32'hDEADBEEF);
    chk("load0_regwrite", WB_RegWrite_o, 1);
    chk("load0_mux", MUX2_o, 5'd3);

    // Store acked after 3 cycles
    issue(0, 0, 0, 0, 0, 1, '0, 32'h44, 32'h12345678, '0, 5'd0, 3, s, r);
    chk("store_stalls", s, 3);
    chk("store_reqs", r, 4);
    chk("store_alu", ALU_result_o, 32'h44);
    chk("store_rdata_held", Read_data_o, 32'hDEADBEEF);

    // Misaligned load
    issue(1, 1, 0, 0, 1, 0, '0, 32'h41, '0, '0, 5'd7, 0, s, r);
    chk("mis_reqs", r, 0);
    chk("mis_bus_err", bus_err_o, 1);
    chk("mis_regwrite", WB_RegWrite_o, 0);

    // Timeout
    issue(1, 1, 0, 0, 1, 0, '0, 32'h80, '0, '0, 5'd9, -1, s, r);
    chk("to_stalls", s, T - 1);
    chk("to_regwrite", WB_RegWrite_o, 0);
    chk("to_bus_err", bus_err_o, 1);
    nop();

    // Branch resolution
    M_branch_i = 1; zero_i = 1; Adder2_i = 32'h100; #1;
    chk("br_taken", PCSrc_o, 1);
    chk("br_target", branch_target_o, 32'h100);
    zero_i = 0; #1;
    chk("br_not_taken", PCSrc_o, 0);
    issue(0, 0, 1, 1, 0, 0, 32'h100, 32'h8, '0, '0, 5'd0, -1, s, r);

    // Reset pulsed during WAIT
    WB_RegWrite_i = 1; WB_MemtoReg_i = 1; M_branch_i = 0; zero_i = 0;
    M_MemRead_i = 1; M_MemWrite_i = 0; ALU_result_i = 32'hC0; MUX2_i = 5'd4;
    dmem_ack_i = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("rstw_req", dmem_req_o, 0);
    chk("rstw_stall", stall_o, 0);
    chk("rstw_regwrite", WB_RegWrite_o, 0);
    chk("rstw_alu", ALU_result_o, 0);
    chk("rstw_bus_err", bus_err_o, 0);
    model_reset();
    M_MemRead_i = 0; WB_RegWrite_i = 0; WB_MemtoReg_i = 0;
    @(posedge clk); #1;
    rst = 0;
    issue(1, 1, 0, 0, 1, 0, '0, 32'h48, '0, 32'hCAFEF00D, 5'd5, 2, s, r);
    chk("post_rst_stalls", s, 2);
    chk("post_rst_rdata", Read_data_o, 32'hCAFEF00D);
    chk("post_rst_regwrite", WB_RegWrite_o, 1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      automatic int unsigned k   = $urandom_range(0, 9);
      automatic logic        rd  = (k >= 4 && k <= 6) || k == 9;
      automatic logic        wr  = (k >= 7);
      automatic logic [DW-1:0] a = {$urandom_range(0, 1023), 2'b00};
      automatic int          lat = ($urandom_range(0, 19) == 0) ? T + 2 : $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), k == 3,
            1'($urandom_range(0, 1)), rd, wr, $urandom, a, $urandom, $urandom,
            5'($urandom_range(0, 31)), (rd | wr) ? lat : -1, s, r);
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
